// File: rtl/dm_if.sv
// Load/store request and response channel between the LSU (master) and the data-memory responder (slave).
interface dm_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data memory answering one load/store at a time after WAIT_CYCLES wait states,
// with byte-enable stores and out-of-range flagging.
module dm_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 4;
  localparam int unsigned CNT_INIT = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  // COMMIT is the single edge on which memory is written and the response is formed.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr_w;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_t            req_q;
  logic [31:0]     mem [DEPTH];

  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            accept_c;
  logic            commit_c;
  logic            err_c;
  logic [AW-1:0]   idx_c;
  logic [31:0]     merged_c;
  logic            unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];

  assign accept_c = (state_q == S_IDLE) && bus.req_valid;
  assign commit_c = (state_q == S_COMMIT);
  assign err_c    = 32'(req_q.addr_w) >= DEPTH;
  assign idx_c    = req_q.addr_w[AW-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(CNT_INIT);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_COMMIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_COMMIT: state_d = S_RESP;
      S_RESP:   if (bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered response outputs
  always_comb begin
    ready_d = (state_d == S_IDLE);
    valid_d = (state_d == S_RESP);
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit_c) begin
      err_d   = err_c;
      rdata_d = (!req_q.we && !err_c) ? mem[idx_c] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  // Request capture; later req_* activity is ignored until the next IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q <= '{we:     bus.req_we,
                 addr_w: bus.req_addr[31:2],
                 be:     bus.req_be,
                 wdata:  bus.req_wdata,
                 pc:     bus.req_pc};
    end
  end

  always_comb begin
    merged_c = mem[idx_c];
    for (int b = 0; b < 4; b++) begin
      if (req_q.be[b]) merged_c[8*b +: 8] = req_q.wdata[8*b +: 8];
    end
  end

  // Memory array: cleared by reset, written only on an in-range store commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit_c && req_q.we && !err_c) begin
      mem[idx_c] <= merged_c;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", req_q.pc, {req_q.addr_w, 2'b00}, merged_c);
`endif
    end
  end

endmodule
